// File: rtl/ps2_key_event_decoder.sv
// PS/2 set-2 key event decoder: prefix FSM, 512-bit key-state bitmap,
// typematic-repeat filter and a first-word fall-through event FIFO.
module ps2_key_event_decoder #(
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned REPEAT_FILTER = 1,
    parameter int unsigned REQUIRE_BAT   = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [7:0]                          rx_data,
    input  logic                                rx_valid,
    input  logic                                rx_err,
    output logic [511:0]                        key_down,
    output logic [8:0]                          last_change,
    output logic                                key_valid,
    output logic                                any_key,
    output logic [10:0]                         evt_data,
    output logic                                evt_valid,
    input  logic                                evt_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count,
    output logic                                overflow,
    output logic                                synced
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StWaitBat,
        StReady,
        StGotE0,
        StGotF0,
        StGotE0F0
    } state_e;

    localparam state_e StInit = (REQUIRE_BAT != 0) ? StWaitBat : StReady;

    function automatic logic is_ignored(input logic [7:0] b);
        return b inside {8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
    endfunction

    state_e state_q, state_d;

    // Decoded event, held one cycle before it touches key state and the FIFO.
    logic       pend_q, pend_d;
    logic       pend_brk_q, pend_brk_d;
    logic [8:0] pend_idx_q, pend_idx_d;
    logic       clr_q, clr_d;

    logic [511:0]    key_down_q, key_down_d;
    logic [8:0]      last_change_q, last_change_d;
    logic            key_valid_q, key_valid_d;
    logic            any_key_q, any_key_d;
    logic            overflow_q, overflow_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [10:0]     mem_q [FIFO_DEPTH];

    logic        is_down;
    logic        is_repeat;
    logic        accept;
    logic        full;
    logic        pop;
    logic        push_ok;
    logic [10:0] evt_word;

    // Prefix FSM and byte decode.
    always_comb begin
        state_d    = state_q;
        pend_d     = 1'b0;
        pend_brk_d = 1'b0;
        pend_idx_d = {1'b0, rx_data};
        clr_d      = 1'b0;
        if (rx_err) begin
            if (state_q != StWaitBat) begin
                state_d = StReady;
            end
        end else if (rx_valid) begin
            unique case (state_q)
                StWaitBat: begin
                    if (rx_data == 8'hAA) begin
                        state_d = StReady;
                    end
                end
                StReady: begin
                    if (rx_data == 8'hE0) begin
                        state_d = StGotE0;
                    end else if (rx_data == 8'hF0) begin
                        state_d = StGotF0;
                    end else if (rx_data == 8'hAA) begin
                        clr_d = 1'b1;
                    end else if (!is_ignored(rx_data)) begin
                        pend_d = 1'b1;
                    end
                end
                StGotE0: begin
                    if (rx_data == 8'hF0) begin
                        state_d = StGotE0F0;
                    end else if (rx_data != 8'hE0) begin
                        pend_d     = 1'b1;
                        pend_idx_d = {1'b1, rx_data};
                        state_d    = StReady;
                    end
                end
                StGotF0: begin
                    pend_d     = 1'b1;
                    pend_brk_d = 1'b1;
                    state_d    = StReady;
                end
                StGotE0F0: begin
                    pend_d     = 1'b1;
                    pend_brk_d = 1'b1;
                    pend_idx_d = {1'b1, rx_data};
                    state_d    = StReady;
                end
                default: state_d = StInit;
            endcase
        end
    end

    // Event apply: key state, repeat filter and FIFO bookkeeping.
    always_comb begin
        is_down   = key_down_q[pend_idx_q];
        is_repeat = !pend_brk_q && is_down;
        accept    = pend_q && !(is_repeat && (REPEAT_FILTER != 0));
        evt_word  = {is_repeat, pend_brk_q, pend_idx_q};
        full      = (count_q == CntW'(FIFO_DEPTH));
        pop       = (count_q != '0) && evt_ready;
        push_ok   = accept && (!full || pop);

        key_down_d = key_down_q;
        if (clr_q) begin
            key_down_d = '0;
        end else if (pend_q) begin
            key_down_d[pend_idx_q] = !pend_brk_q;
        end

        key_valid_d   = accept;
        last_change_d = accept ? pend_idx_q : last_change_q;
        any_key_d     = |key_down_q;
        overflow_d    = overflow_q | (accept && full && !pop);

        wr_ptr_d = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= StInit;
            pend_q        <= 1'b0;
            pend_brk_q    <= 1'b0;
            pend_idx_q    <= '0;
            clr_q         <= 1'b0;
            key_down_q    <= '0;
            last_change_q <= '0;
            key_valid_q   <= 1'b0;
            any_key_q     <= 1'b0;
            overflow_q    <= 1'b0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            pend_brk_q    <= pend_brk_d;
            pend_idx_q    <= pend_idx_d;
            clr_q         <= clr_d;
            key_down_q    <= key_down_d;
            last_change_q <= last_change_d;
            key_valid_q   <= key_valid_d;
            any_key_q     <= any_key_d;
            overflow_q    <= overflow_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read while the count is non-zero.
    always_ff @(posedge clk) begin
        if (rst && push_ok) begin
            mem_q[wr_ptr_q] <= evt_word;
        end
    end

    assign key_down    = key_down_q;
    assign last_change = last_change_q;
    assign key_valid   = key_valid_q;
    assign any_key     = any_key_q;
    assign overflow    = overflow_q;
    assign fifo_count  = count_q;
    assign evt_valid   = (count_q != '0);
    assign evt_data    = evt_valid ? mem_q[rd_ptr_q] : '0;
    assign synced      = (state_q != StWaitBat);

endmodule
